// File: rtl/dmem_store_buffer.sv
// Data-memory stage controller: an in-order store buffer with load forwarding in front
// of a req/ack data RAM. Load misses stall the core until the RAM read completes.
module dmem_store_buffer #(
   parameter int WBUF_DEPTH = 4
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        cpu_memread,
   input  logic        cpu_memwrite,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        wbuf_empty,
   output logic        ram_req,
   output logic        ram_we,
   output logic [29:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack
);
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_LOAD} state_t;

   state_t                state_q;
   logic [29:0]           addr_mem_q [WBUF_DEPTH];
   logic [31:0]           data_mem_q [WBUF_DEPTH];
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         tail_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  ram_req_q;
   logic                  ram_we_q;
   logic [29:0]           ram_addr_q;
   logic [31:0]           ram_wdata_q;
   logic                  wbuf_empty_q;

   logic [29:0]           cpu_word;
   logic                  full;
   logic                  do_store;
   logic                  do_load;
   logic                  drain_ack;
   logic                  load_miss;
   logic                  load_done;
   logic [WBUF_DEPTH-1:0] entry_hit;
   logic                  fwd_hit;
   logic [31:0]           fwd_data;
   logic [PW-1:0]         fwd_idx;
   logic                  unused_addr_lsbs;

   assign cpu_word         = cpu_addr[31:2];
   assign unused_addr_lsbs = ^cpu_addr[1:0];
   assign full             = (count_q == CW'(WBUF_DEPTH));
   assign do_store         = cpu_memwrite & ~full;
   assign do_load          = cpu_memread & ~cpu_memwrite;
   assign drain_ack        = (state_q == ST_DRAIN) & ram_ack;
   assign load_done        = (state_q == ST_LOAD) & ram_ack;
   assign count_d          = count_q + CW'(do_store) - CW'(drain_ack);

   // An entry is live when its distance from head is below the occupancy count.
   genvar gi;
   generate
      for (gi = 0; gi < WBUF_DEPTH; gi++) begin : g_entry
         logic [PW-1:0] age;
         assign age           = PW'(gi) - head_q;
         assign entry_hit[gi] = ({1'b0, age} < count_q) && (addr_mem_q[gi] == cpu_word);
      end
   endgenerate

   // Walk oldest to youngest so the youngest matching store wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         fwd_idx = head_q + PW'(i);
         if (entry_hit[fwd_idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem_q[fwd_idx];
         end
      end
   end

   assign load_miss = do_load & ~fwd_hit;
   assign cpu_stall = ~rst & ((cpu_memwrite & full) | (load_miss & ~load_done));

   always_comb begin
      cpu_rdata = '0;
      if (~rst & do_load) begin
         if (fwd_hit) begin
            cpu_rdata = fwd_data;
         end else if (load_done) begin
            cpu_rdata = ram_rdata;
         end
      end
   end

   always_ff @(posedge clka) begin
      if (do_store) begin
         addr_mem_q[tail_q] <= cpu_word;
         data_mem_q[tail_q] <= cpu_wdata;
      end
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         wbuf_empty_q <= 1'b1;
         ram_req_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         if (do_store) begin
            tail_q <= tail_q + PW'(1);
         end
         if (drain_ack) begin
            head_q <= head_q + PW'(1);
         end
         count_q      <= count_d;
         wbuf_empty_q <= (count_d == '0);
         case (state_q)
            ST_IDLE: begin
               // A buffered store to the same word would have hit, so reads may bypass drains.
               if (load_miss) begin
                  state_q    <= ST_LOAD;
                  ram_req_q  <= 1'b1;
                  ram_we_q   <= 1'b0;
                  ram_addr_q <= cpu_word;
               end else if (count_q != '0) begin
                  state_q     <= ST_DRAIN;
                  ram_req_q   <= 1'b1;
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= addr_mem_q[head_q];
                  ram_wdata_q <= data_mem_q[head_q];
               end
            end
            ST_DRAIN: begin
               if (ram_ack) begin
                  state_q   <= ST_IDLE;
                  ram_req_q <= 1'b0;
                  ram_we_q  <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (ram_ack) begin
                  state_q   <= ST_IDLE;
                  ram_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               ram_req_q <= 1'b0;
               ram_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wbuf_empty = wbuf_empty_q;
   assign ram_req    = ram_req_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: a per-cycle vector table plus hand-written
// sequences for full-buffer, miss-behind-drain and reset-during-load cases.
module tb_dmem_store_buffer;
   logic        clka;
   logic        rst;
   logic        cpu_memread;
   logic        cpu_memwrite;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        wbuf_empty;
   logic        ram_req;
   logic        ram_we;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   dmem_store_buffer #(.WBUF_DEPTH(4)) dut (
      .clka(clka), .rst(rst),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .wbuf_empty(wbuf_empty),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rram;
      logic        e_stall;
      logic [31:0] e_rdata;
      logic        e_req;
      logic        e_we;
      logic [29:0] e_raddr;
      logic [31:0] e_wdata;
      logic        e_empty;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ack, input logic [31:0] rram,
                               input logic e_stall, input logic [31:0] e_rdata, input logic e_req,
                               input logic e_we, input logic [29:0] e_raddr,
                               input logic [31:0] e_wdata, input logic e_empty);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rram = rram;
      v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_req = e_req; v.e_we = e_we;
      v.e_raddr = e_raddr; v.e_wdata = e_wdata; v.e_empty = e_empty;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // One clock: inputs change 1ns after the rising edge, outputs sampled at the falling edge.
   task automatic cyc(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] rr);
      @(posedge clka);
      #1;
      rst = r; cpu_memread = rd; cpu_memwrite = wr; cpu_addr = a; cpu_wdata = wd;
      ram_ack = ack; ram_rdata = rr;
      @(negedge clka);
      ncyc++;
      $display("cyc %0d rst=%0b rd=%0b wr=%0b addr=%08h ack=%0b | stall=%0b rdata=%08h req=%0b we=%0b raddr=%08h empty=%0b",
               ncyc, r, rd, wr, a, ack, cpu_stall, cpu_rdata, ram_req, ram_we, ram_addr, wbuf_empty);
   endtask

   task automatic exp_core(input string tag, input logic st, input logic [31:0] rd);
      chk({tag, " stall"}, {31'b0, cpu_stall}, {31'b0, st});
      chk({tag, " rdata"}, cpu_rdata, rd);
   endtask

   task automatic exp_ram(input string tag, input logic req, input logic we,
                          input logic [29:0] a, input logic [31:0] wd);
      chk({tag, " ram_req"}, {31'b0, ram_req}, {31'b0, req});
      if (req) begin
         chk({tag, " ram_we"}, {31'b0, ram_we}, {31'b0, we});
         chk({tag, " ram_addr"}, {2'b0, ram_addr}, {2'b0, a});
         if (we) chk({tag, " ram_wdata"}, ram_wdata, wd);
      end
   endtask

   task automatic exp_empty(input string tag, input logic e);
      chk({tag, " wbuf_empty"}, {31'b0, wbuf_empty}, {31'b0, e});
   endtask

   initial begin
      rst = 1'b1; cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ram_ack = 1'b0; ram_rdata = '0;

      //             rd wr addr    wdata         ack rram | stall rdata        req we raddr  wdata         empty
      vecs[0]  = mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);
      vecs[1]  = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        0);
      vecs[2]  = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            1, 1, 30'h4, 32'hDEADBEEF, 0);
      vecs[3]  = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            1, 1, 30'h4, 32'hDEADBEEF, 0);
      vecs[4]  = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            1, 1, 30'h4, 32'hDEADBEEF, 0);
      vecs[5]  = mk(0, 0, 32'h0,  32'h0,        1, 0,     0, 0,            1, 1, 30'h4, 32'hDEADBEEF, 0);
      vecs[6]  = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);
      vecs[7]  = mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);
      vecs[8]  = mk(1, 0, 32'h10, 32'h0,        0, 0,     0, 32'hDEADBEEF, 0, 0, 30'h0, 32'h0,        0);
      vecs[9]  = mk(0, 0, 32'h0,  32'h0,        1, 0,     0, 0,            1, 1, 30'h4, 32'hDEADBEEF, 0);
      vecs[10] = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);
      vecs[11] = mk(0, 1, 32'h20, 32'h1,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);
      vecs[12] = mk(0, 1, 32'h20, 32'h2,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        0);
      vecs[13] = mk(1, 0, 32'h22, 32'h0,        0, 0,     0, 32'h2,        1, 1, 30'h8, 32'h1,        0);
      vecs[14] = mk(0, 0, 32'h20, 32'h0,        1, 0,     0, 0,            1, 1, 30'h8, 32'h1,        0);
      vecs[15] = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        0);
      vecs[16] = mk(0, 0, 32'h0,  32'h0,        1, 0,     0, 0,            1, 1, 30'h8, 32'h2,        0);
      vecs[17] = mk(0, 0, 32'h0,  32'h0,        0, 0,     0, 0,            0, 0, 30'h0, 32'h0,        1);

      // Reset state
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      exp_core("reset", 0, 0);
      chk("reset ram_req", {31'b0, ram_req}, 32'h0);
      chk("reset ram_we", {31'b0, ram_we}, 32'h0);
      chk("reset ram_addr", {2'b0, ram_addr}, 32'h0);
      chk("reset ram_wdata", ram_wdata, 32'h0);
      exp_empty("reset", 1);

      // Single store drain, forwarding hit, youngest-entry forwarding
      for (int i = 0; i < 18; i++) begin
         cyc(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rram);
         exp_core($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_rdata);
         exp_ram($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_we, vecs[i].e_raddr, vecs[i].e_wdata);
         exp_empty($sformatf("v%0d", i), vecs[i].e_empty);
      end

      // Full buffer: fifth store stalls until the first drain ack
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 0, 0);
         exp_core($sformatf("full store%0d", i), 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 1, 32'h110, 32'hA000_0004, 0, 0);
         exp_core($sformatf("full wait%0d", i), 1, 0);
         exp_ram($sformatf("full wait%0d", i), 1, 1, 30'h40, 32'hA000_0000);
      end
      cyc(0, 0, 1, 32'h110, 32'hA000_0004, 1, 0);
      exp_core("full ack", 1, 0);
      exp_ram("full ack", 1, 1, 30'h40, 32'hA000_0000);
      cyc(0, 0, 1, 32'h110, 32'hA000_0004, 0, 0);
      exp_core("full accept", 0, 0);
      exp_ram("full accept", 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h110, 0, 0, 0);
      exp_core("full fwd", 0, 32'hA000_0004);
      exp_ram("full fwd", 1, 1, 30'h41, 32'hA000_0001);
      for (int j = 1; j <= 4; j++) begin
         cyc(0, 0, 0, 0, 0, 1, 0);
         exp_ram($sformatf("full drain%0d", j), 1, 1, 30'h40 + 30'(j), 32'hA000_0000 + 32'(j));
         cyc(0, 0, 0, 0, 0, 0, 0);
         exp_ram($sformatf("full gap%0d", j), 0, 0, 0, 0);
         exp_empty($sformatf("full gap%0d", j), j == 4);
      end

      // Load miss arriving while a drain is outstanding
      cyc(0, 0, 1, 32'h30, 32'h55, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h40, 0, 0, 0);
      exp_core("miss pend", 1, 0);
      exp_ram("miss pend", 1, 1, 30'hC, 32'h55);
      cyc(0, 1, 0, 32'h40, 0, 1, 32'hFFFF_FFFF);
      exp_core("miss drainack", 1, 0);
      exp_ram("miss drainack", 1, 1, 30'hC, 32'h55);
      cyc(0, 1, 0, 32'h40, 0, 0, 0);
      exp_core("miss idle", 1, 0);
      exp_ram("miss idle", 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h40, 0, 0, 0);
      exp_core("miss load", 1, 0);
      exp_ram("miss load", 1, 0, 30'h10, 0);
      cyc(0, 1, 0, 32'h40, 0, 1, 32'h1234_5678);
      exp_core("miss ack", 0, 32'h1234_5678);
      exp_ram("miss ack", 1, 0, 30'h10, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      exp_core("miss done", 0, 0);
      exp_ram("miss done", 0, 0, 0, 0);
      exp_empty("miss done", 1);

      // Reset while a load is outstanding with two stores buffered
      cyc(0, 0, 1, 32'h50, 32'h1, 0, 0);
      cyc(0, 0, 1, 32'h54, 32'h2, 0, 0);
      cyc(0, 0, 1, 32'h58, 32'h3, 0, 0);
      exp_ram("rst drain", 1, 1, 30'h14, 32'h1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 32'h60, 0, 0, 0);
      exp_core("rst miss", 1, 0);
      cyc(0, 1, 0, 32'h60, 0, 0, 0);
      exp_core("rst inload", 1, 0);
      exp_ram("rst inload", 1, 0, 30'h18, 0);
      exp_empty("rst inload", 0);
      cyc(1, 1, 0, 32'h60, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      exp_core("rst after", 0, 0);
      exp_ram("rst after", 0, 0, 0, 0);
      exp_empty("rst after", 1);
      cyc(0, 1, 0, 32'h50, 0, 0, 0);
      exp_core("rst discarded", 1, 0);
      exp_ram("rst discarded", 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h50, 0, 1, 32'h0BAD_F00D);
      exp_core("rst reload", 0, 32'h0BAD_F00D);
      exp_ram("rst reload", 1, 0, 30'h14, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      exp_ram("rst final", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
